// File: rtl/set_assoc_instruction_cache.sv
// set_assoc_instruction_cache: 1/2-way read-only I-cache with multi-beat block refill,
// LRU replacement, 16-bit-aligned fetch straddling lines, and invalidate-all.
module set_assoc_instruction_cache #(
  parameter int L2_CACHE_SIZE = 10,
  parameter int L2_BLOCK_SIZE = 4,
  parameter int L2_WAYS       = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_cache_enable,
  input  logic [63:0] inst_cache_addr,
  input  logic        inst_cache_invalidate,
  output logic [63:0] inst_cache_data,
  output logic        inst_cache_busy,
  output logic        inst_enable,
  output logic [63:0] inst_addr,
  input  logic [63:0] inst_data,
  input  logic        inst_busy
);
  localparam int WAYS  = 1 << L2_WAYS;
  localparam int BEATS = 1 << (L2_BLOCK_SIZE - 3);
  localparam int BTW   = L2_BLOCK_SIZE > 3 ? L2_BLOCK_SIZE - 3 : 1;
  localparam int LB    = L2_CACHE_SIZE - L2_WAYS;
  localparam int SETS  = 1 << (LB - L2_BLOCK_SIZE);
  localparam int LW    = 64 * BEATS;
  localparam logic [63:0] BLK = 64'd1 << L2_BLOCK_SIZE;
  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, FILL, LOOKUP2} state_t;
  state_t state_q, state_d;
  logic [63:0] addr_q, addr_d, data_q, data_d;
  logic half_q, half_d, pend_q, pend_d, victim_q, victim_d;
  logic [15:0] lo_q, lo_d;
  logic [BTW-1:0] beat_q, beat_d;
  logic [BEATS-1:0][63:0] fill_buf_q, fill_buf_d;
  logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0] lru_q, lru_d;
  logic [LW-1:0] line_q [WAYS][SETS];
  logic [63-LB:0] tag_q [WAYS][SETS];
  logic [63:0] look_addr;
  logic [LB-L2_BLOCK_SIZE-1:0] idx;
  logic [63-LB:0] tag;
  logic hit, hit_way, vict, straddle;
  logic [LW-1:0] line;
  logic [31:0] word;
  // half_q selects the following line while completing a straddling fetch
  always_comb begin
    look_addr = half_q ? addr_q + BLK : addr_q;
    idx = look_addr[LB-1:L2_BLOCK_SIZE];
    tag = look_addr[63:LB];
    hit = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = 1'(w);
      end
    vict = (L2_WAYS == 0 || !valid_q[0][idx]) ? 1'b0 : !valid_q[WAYS-1][idx] ? 1'b1 : lru_q[idx];
    line = line_q[hit_way][idx];
    word = 32'(line >> {addr_q[L2_BLOCK_SIZE-1:1], 4'b0});
    straddle = &addr_q[L2_BLOCK_SIZE-1:1];
  end
  assign inst_cache_busy = state_q != IDLE;
  assign inst_enable = state_q == REQ;
  assign inst_addr = (state_q == REQ || state_q == WAIT) ?
                     (look_addr & ~(BLK - 64'd1)) + 64'({beat_q, 3'b000}) : 64'd0;
  assign inst_cache_data = data_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    half_d = half_q;
    lo_d = lo_q;
    victim_d = victim_q;
    beat_d = beat_q;
    fill_buf_d = fill_buf_q;
    valid_d = valid_q;
    lru_d = lru_q;
    pend_d = pend_q | inst_cache_invalidate;
    case (state_q)
      IDLE: begin
        half_d = 1'b0;
        if (pend_d) begin
          valid_d = '0;
          pend_d = 1'b0;
        end
        if (inst_cache_enable) begin
          addr_d = inst_cache_addr & ~64'd1;
          state_d = LOOKUP;
        end
      end
      LOOKUP, LOOKUP2: begin
        if (hit) begin
          if (L2_WAYS != 0) lru_d[idx] = ~hit_way;
          if (state_q == LOOKUP2) begin
            data_d = {32'b0, line[15:0], lo_q};
            state_d = IDLE;
          end else if (straddle) begin
            lo_d = word[15:0];
            half_d = 1'b1;
            state_d = LOOKUP2;
          end else begin
            data_d = {32'b0, word};
            state_d = IDLE;
          end
        end else begin
          victim_d = vict;
          beat_d = '0;
          state_d = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (!inst_busy) begin
          fill_buf_d[beat_q] = inst_data;
          if (beat_q == BTW'(BEATS - 1)) state_d = FILL;
          else begin
            beat_d = beat_q + 1'b1;
            state_d = REQ;
          end
        end
      end
      FILL: begin
        valid_d[victim_q][idx] = 1'b1;
        if (L2_WAYS != 0) lru_d[idx] = ~victim_q;
        state_d = half_q ? LOOKUP2 : LOOKUP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      half_q <= 1'b0;
      lo_q <= '0;
      victim_q <= 1'b0;
      beat_q <= '0;
      fill_buf_q <= '0;
      valid_q <= '0;
      lru_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      half_q <= half_d;
      lo_q <= lo_d;
      victim_q <= victim_d;
      beat_q <= beat_d;
      fill_buf_q <= fill_buf_d;
      valid_q <= valid_d;
      lru_q <= lru_d;
      pend_q <= pend_d;
    end
  end
  // whole block and tag land together; the valid bit rises on the same edge
  always_ff @(posedge clock) begin
    if (state_q == FILL) begin
      line_q[victim_q][idx] <= fill_buf_q;
      tag_q[victim_q][idx] <= tag;
    end
  end
endmodule
